// File: rtl/axi_frame_writer_if.sv
// axi_frame_writer_if: AXI3 write-address, write-data and write-response signals between the frame writer and the PS HP port
interface axi_frame_writer_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [2:0]  awprot;
  logic [3:0]  awcache;
  logic [3:0]  awqos;
  logic [5:0]  awid;
  logic        wvalid;
  logic        wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic [5:0]  wid;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [5:0]  bid;
  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awlock, awprot, awcache, awqos, awid,
    output wvalid, wdata, wstrb, wlast, wid, bready,
    input  awready, wready, bvalid, bresp, bid
  );
  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awlock, awprot, awcache, awqos, awid,
    input  wvalid, wdata, wstrb, wlast, wid, bready,
    output awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/axi_frame_writer.sv
// axi_frame_writer: buffers a 64-bit pixel stream and writes it as 16-beat AXI3 INCR bursts into a circular frame region
module axi_frame_writer #(
  parameter logic [31:0] BASE        = 32'h2000_0000,
  parameter int          FRAME_WORDS = 1036800,
  parameter int          FIFO_DEPTH  = 64,
  parameter int          MAX_OUT     = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                sof_i,
  input  logic [63:0]         data_i,
  input  logic                valid_i,
  output logic                overflow_o,
  output logic                err_o,
  output logic                frame_done_o,
  axi_frame_writer_if.master  m_axi
);
  localparam int NB = FRAME_WORDS / 16;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, AW, W} state_t;
  state_t state, state_n;

  logic [63:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [BW-1:0] burst_idx;
  logic [OW-1:0] outstanding;
  logic [3:0]    beat;
  logic          sof_pending;
  logic          accept, full, push, pop, flush, aw_hs, last_burst;

  assign accept     = valid_i && en_i && !sof_pending;
  assign full       = count == CW'(FIFO_DEPTH);
  assign push       = accept && !full;
  assign pop        = state == W && m_axi.wready;
  assign flush      = state == IDLE && sof_pending;
  assign aw_hs      = state == AW && m_axi.awready;
  assign last_burst = burst_idx == BW'(NB - 1);

  // A pending frame restart blocks new bursts so the flush wins in IDLE
  always_comb begin
    state_n = state;
    if (state == IDLE && !sof_pending && count >= CW'(16) && outstanding < OW'(MAX_OUT))
      state_n = AW;
    else if (aw_hs)
      state_n = W;
    else if (pop && beat == 4'd15)
      state_n = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      burst_idx   <= '0;
      outstanding <= '0;
      beat        <= '0;
      sof_pending <= 1'b0;
      overflow_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_n;
      sof_pending <= sof_i || (sof_pending && !flush);
      outstanding <= outstanding + OW'(aw_hs) - OW'(m_axi.bvalid);
      if (pop) beat <= beat + 4'd1;
      if (m_axi.bvalid && m_axi.bresp != 2'b00) err_o <= 1'b1;
      if (flush) begin
        wptr       <= '0;
        rptr       <= '0;
        count      <= '0;
        burst_idx  <= '0;
        overflow_o <= 1'b0;
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (pop) rptr <= rptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (accept && full) overflow_o <= 1'b1;
        if (aw_hs) burst_idx <= last_burst ? '0 : burst_idx + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= data_i;
  end

  assign frame_done_o  = aw_hs && last_burst;
  assign m_axi.awvalid = state == AW;
  assign m_axi.awaddr  = BASE + (32'(burst_idx) << 7);
  assign m_axi.awlen   = 4'd15;
  assign m_axi.awsize  = 3'd3;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 2'b00;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awqos   = 4'd0;
  assign m_axi.awid    = 6'd0;
  assign m_axi.wvalid  = state == W;
  assign m_axi.wdata   = mem[rptr];
  assign m_axi.wstrb   = 8'hFF;
  assign m_axi.wlast   = state == W && beat == 4'd15;
  assign m_axi.wid     = 6'd0;
  assign m_axi.bready  = 1'b1;
endmodule

// File: tb/tb_axi_frame_writer.sv
// tb_axi_frame_writer: directed checks of the frame writer; a second instance uses a 64-word frame to exercise wrap-around
module tb_axi_frame_writer;
  localparam logic [31:0] BASE = 32'h2000_0000;
  logic clk = 0, rst, en, sof, valid;
  logic [63:0] data;
  logic awready, wready, bvalid;
  logic [1:0] bresp;
  logic ovf_a, err_a, fd_a, ovf_b, err_b, fd_b;
  int checks = 0, errors = 0;
  logic [31:0] awa[$], awb[$];
  logic [63:0] wd_a[$];
  logic wl_a[$];
  int fd_a_cnt = 0, fd_b_cnt = 0, fd_b_at = 0;

  axi_frame_writer_if ia();
  axi_frame_writer_if ib();
  assign ia.awready = awready;
  assign ia.wready  = wready;
  assign ia.bvalid  = bvalid;
  assign ia.bresp   = bresp;
  assign ia.bid     = 6'd0;
  assign ib.awready = awready;
  assign ib.wready  = wready;
  assign ib.bvalid  = bvalid;
  assign ib.bresp   = bresp;
  assign ib.bid     = 6'd0;

  axi_frame_writer dut_a (.clk_i(clk), .rst_i(rst), .en_i(en), .sof_i(sof), .data_i(data), .valid_i(valid),
    .overflow_o(ovf_a), .err_o(err_a), .frame_done_o(fd_a), .m_axi(ia));
  axi_frame_writer #(.FRAME_WORDS(64)) dut_b (.clk_i(clk), .rst_i(rst), .en_i(en), .sof_i(sof), .data_i(data),
    .valid_i(valid), .overflow_o(ovf_b), .err_o(err_b), .frame_done_o(fd_b), .m_axi(ib));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ia.awvalid && ia.awready) awa.push_back(ia.awaddr);
    if (ia.wvalid && ia.wready) begin
      wd_a.push_back(ia.wdata);
      wl_a.push_back(ia.wlast);
    end
    if (fd_a) fd_a_cnt++;
    if (ib.awvalid && ib.awready) awb.push_back(ib.awaddr);
    if (fd_b) begin
      fd_b_cnt++;
      fd_b_at = awb.size();
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      valid = 1;
      data = 64'(start + i);
      step();
    end
    valid = 0;
  endtask

  task automatic clear_logs();
    awa.delete();
    awb.delete();
    wd_a.delete();
    wl_a.delete();
    fd_a_cnt = 0;
    fd_b_cnt = 0;
    fd_b_at = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step(2);
    rst = 0;
    clear_logs();
  endtask

  task automatic b_pulse(input int n);
    bvalid = 1;
    step(n);
    bvalid = 0;
  endtask

  initial begin
    rst = 1; en = 1; sof = 0; valid = 0; data = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    step(3);
    chk("rst_awvalid", 64'(ia.awvalid), 64'(0));
    chk("rst_wvalid", 64'(ia.wvalid), 64'(0));
    chk("rst_wlast", 64'(ia.wlast), 64'(0));
    chk("rst_overflow", 64'(ovf_a), 64'(0));
    chk("rst_err", 64'(err_a), 64'(0));
    chk("rst_frame_done", 64'(fd_a), 64'(0));
    chk("bready", 64'(ia.bready), 64'(1));
    rst = 0;
    clear_logs();

    // Single burst with both channels ready
    awready = 1; wready = 1;
    push(16, 0);
    chk("aw_latency_before", 64'(ia.awvalid), 64'(0));
    step();
    chk("aw_latency_after", 64'(ia.awvalid), 64'(1));
    chk("awlen", 64'(ia.awlen), 64'(15));
    chk("awsize", 64'(ia.awsize), 64'(3));
    chk("awburst", 64'(ia.awburst), 64'(1));
    chk("awcache", 64'(ia.awcache), 64'(3));
    step(20);
    chk("b1_aw_count", 64'(awa.size()), 64'(1));
    chk("b1_awaddr", 64'(awa[0]), 64'(BASE));
    chk("b1_w_count", 64'(wd_a.size()), 64'(16));
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b1_wdata%0d", i), wd_a[i], 64'(i));
      chk($sformatf("b1_wlast%0d", i), 64'(wl_a[i]), 64'(i == 15));
    end
    chk("b1_fifo_empty", 64'(dut_a.count), 64'(0));
    chk("b1_wvalid_idle", 64'(ia.wvalid), 64'(0));
    b_pulse(1);
    clear_logs();

    // AW stalled by the slave
    awready = 0;
    push(16, 16);
    step();
    for (int i = 0; i < 10; i++) begin
      chk("stall_awvalid", 64'(ia.awvalid), 64'(1));
      chk("stall_awaddr", 64'(ia.awaddr), 64'(BASE + 32'h80));
      chk("stall_wvalid", 64'(ia.wvalid), 64'(0));
      step();
    end
    awready = 1;
    step(20);
    chk("stall_aw_count", 64'(awa.size()), 64'(1));
    chk("stall_awaddr_hs", 64'(awa[0]), 64'(BASE + 32'h80));
    chk("stall_wdata_first", wd_a[0], 64'(16));
    chk("stall_wdata_last", wd_a[15], 64'(31));
    b_pulse(1);

    // Outstanding limit, and frame wrap on the 64-word instance
    do_reset();
    awready = 1; wready = 1;
    push(80, 100);
    step(30);
    chk("lim_aw_count", 64'(awa.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lim_awaddr%0d", i), 64'(awa[i]), 64'(BASE + 32'(i * 128)));
      chk($sformatf("wrap_awaddr%0d", i), 64'(awb[i]), 64'(BASE + 32'(i * 128)));
    end
    chk("lim_fifo_hold", 64'(dut_a.count), 64'(16));
    chk("wrap_fd_count", 64'(fd_b_cnt), 64'(1));
    chk("wrap_fd_at", 64'(fd_b_at), 64'(4));
    chk("nowrap_fd_count", 64'(fd_a_cnt), 64'(0));
    b_pulse(1);
    step(25);
    chk("lim_aw_count5", 64'(awa.size()), 64'(5));
    chk("lim_awaddr4", 64'(awa[4]), 64'(BASE + 32'h200));
    chk("wrap_awaddr4", 64'(awb[4]), 64'(BASE));
    chk("lim_wdata64", wd_a[64], 64'(164));
    chk("wrap_fd_count2", 64'(fd_b_cnt), 64'(1));
    b_pulse(4);

    // Overflow with W stalled, then sof during W flushes and restarts at BASE
    do_reset();
    awready = 1; wready = 0;
    push(64, 400);
    chk("ovf_full_count", 64'(dut_a.count), 64'(64));
    chk("ovf_not_yet", 64'(ovf_a), 64'(0));
    push(6, 464);
    chk("ovf_count", 64'(dut_a.count), 64'(64));
    chk("ovf_set", 64'(ovf_a), 64'(1));
    chk("ovf_wvalid", 64'(ia.wvalid), 64'(1));
    chk("ovf_wdata_head", ia.wdata, 64'(400));
    sof = 1;
    step();
    sof = 0;
    push(3, 900);
    chk("sof_drop_silent", 64'(ovf_a), 64'(1));
    chk("sof_drop_count", 64'(dut_a.count), 64'(64));
    wready = 1;
    step(25);
    chk("sof_burst_done", 64'(wd_a.size()), 64'(16));
    chk("sof_burst_last", wd_a[15], 64'(415));
    chk("sof_ovf_clear", 64'(ovf_a), 64'(0));
    chk("sof_flushed", 64'(dut_a.count), 64'(0));
    chk("sof_no_aw", 64'(ia.awvalid), 64'(0));
    step(40);
    push(16, 300);
    step(22);
    chk("sof_aw_count", 64'(awa.size()), 64'(2));
    chk("sof_restart_addr", 64'(awa[1]), 64'(BASE));
    chk("sof_restart_first", wd_a[16], 64'(300));
    chk("sof_restart_last", wd_a[31], 64'(315));

    // Disabled input is dropped without overflow
    en = 0;
    push(5, 700);
    chk("en_off_count", 64'(dut_a.count), 64'(0));
    chk("en_off_ovf", 64'(ovf_a), 64'(0));
    en = 1;

    // Sticky error response
    chk("err_before", 64'(err_a), 64'(0));
    bresp = 2'b10;
    b_pulse(1);
    bresp = 2'b00;
    chk("err_set", 64'(err_a), 64'(1));
    b_pulse(1);
    step(3);
    chk("err_sticky", 64'(err_a), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
